// File: rtl/weight_config_loader_if.sv
// Host word stream into the weight configuration loader.
// The master is the host bridge; the slave is the loader.
interface weight_config_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/weight_config_loader.sv
// Parses framed host words (header + count weights) and broadcasts tagged weight strobes
// to the per-neuron weight memory controllers.
//
//  state | meaning
//  HDR   | next accepted word is a block header
//  WGT   | next accepted word is a weight of the current block
module weight_config_loader #(
  parameter int LAYER_BITS  = 8,
  parameter int NEURON_BITS = 12,
  parameter int COUNT_BITS  = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  weight_config_loader_if.slave  host,
  output logic                   weight_valid,
  output logic [31:0]            weight_value,
  output logic [31:0]            config_layer_no,
  output logic [31:0]            config_neuron_no,
  output logic                   busy,
  output logic                   load_done,
  output logic                   err_short,
  output logic [15:0]            blocks_loaded
);

  typedef enum logic {HDR, WGT} state_t;

  state_t                 state;
  logic [LAYER_BITS-1:0]  layer;
  logic [NEURON_BITS-1:0] neuron;
  logic [COUNT_BITS-1:0]  rem;
  logic                   accept;

  assign accept = host.s_valid & host.s_ready;
  assign busy   = (state == WGT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= HDR;
      host.s_ready     <= 1'b0;
      layer            <= '0;
      neuron           <= '0;
      rem              <= '0;
      weight_valid     <= 1'b0;
      weight_value     <= '0;
      config_layer_no  <= '0;
      config_neuron_no <= '0;
      load_done        <= 1'b0;
      err_short        <= 1'b0;
      blocks_loaded    <= '0;
    end else begin
      host.s_ready <= 1'b1;
      weight_valid <= 1'b0;
      load_done    <= 1'b0;
      if (accept) begin
        case (state)
          HDR: begin
            layer  <= host.s_data[31 -: LAYER_BITS];
            neuron <= host.s_data[COUNT_BITS +: NEURON_BITS];
            rem    <= host.s_data[COUNT_BITS-1:0];
            if (host.s_data[COUNT_BITS-1:0] == '0) begin
              if (host.s_last) load_done <= 1'b1;
            end else if (host.s_last) begin
              err_short <= 1'b1;
            end else begin
              state <= WGT;
            end
          end
          WGT: begin
            // The tag is published only alongside a weight, never on the header beat.
            weight_valid     <= 1'b1;
            weight_value     <= host.s_data;
            config_layer_no  <= {{(32-LAYER_BITS){1'b0}}, layer};
            config_neuron_no <= {{(32-NEURON_BITS){1'b0}}, neuron};
            rem              <= rem - 1'b1;
            if (rem == COUNT_BITS'(1)) begin
              state <= HDR;
              if (blocks_loaded != 16'hFFFF) blocks_loaded <= blocks_loaded + 16'd1;
              if (host.s_last) load_done <= 1'b1;
            end else if (host.s_last) begin
              err_short <= 1'b1;
              state     <= HDR;
            end
          end
          default: state <= HDR;
        endcase
      end
    end
  end

endmodule
